tag_word_packer: RTL and testbench

TAG_WORD_PACKER -- requirements
Module: tag_word_packer

---
 rtl/tag_word_packer.sv | 121 ++++++++++++
 tb/tb_tag_word_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tag_word_packer
// Description : Gathers DATA_LENGTH-bit tag words from an upstream one-entry
//               FIFO into packets of up to WORDS lanes. A packet is launched
//               when the accumulator is full, on a flush request, or after
//               TIMEOUT idle cycles with a partial packet held. Lane 0 holds
//               the first word; unused lanes are zero.
// Ports       : clk          - rising-edge clock
//               rstn         - synchronous active-low reset
//               fifo_data_i  - head word of upstream FIFO (valid when !empty_i)
//               empty_i      - upstream FIFO empty flag
//               read_o       - pop strobe; the word is consumed at the edge
//               flush_i      - single-cycle request to emit a partial packet
//               out_data_o   - packed packet, first word in lane 0
//               out_nwords_o - number of valid lanes (1..WORDS)
//               out_valid_o  - packet valid
//               out_ready_i  - downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
module tag_word_packer #(
    parameter int DATA_LENGTH = 32,
    parameter int WORDS       = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_LENGTH-1:0]       fifo_data_i,
    input  logic                         empty_i,
    output logic                         read_o,
    input  logic                         flush_i,
    output logic [DATA_LENGTH*WORDS-1:0] out_data_o,
    output logic [$clog2(WORDS):0]       out_nwords_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i
);

    localparam int              c_CW   = $clog2(WORDS) + 1;
    localparam int              c_IW   = $clog2(TIMEOUT + 1);
    localparam int              c_PW   = DATA_LENGTH * WORDS;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(WORDS);
    localparam logic [c_IW-1:0] c_TMO  = c_IW'(TIMEOUT);

    logic [c_PW-1:0] r_acc;
    logic [c_CW-1:0] r_cnt;
    logic [c_IW-1:0] r_idle;
    logic            r_flush_pend;

    logic            w_slot_free;
    logic            w_launch;
    logic [c_PW-1:0] w_masked;

    assign read_o      = rstn & ~empty_i & (r_cnt < c_FULL);
    assign w_slot_free = ~out_valid_o | out_ready_i;
    assign w_launch    = w_slot_free & (r_cnt != '0) &
                         ((r_cnt == c_FULL) | flush_i | r_flush_pend | (r_idle == c_TMO));

    // Lanes at or above the fill count are forced to zero so a stale lane can
    // never leak into a short packet.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (c_CW'(i) < r_cnt) begin
                w_masked[i*DATA_LENGTH +: DATA_LENGTH] = r_acc[i*DATA_LENGTH +: DATA_LENGTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_flush_pend <= 1'b0;
            out_data_o   <= '0;
            out_nwords_o <= '0;
            out_valid_o  <= 1'b0;
        end else begin
            if (w_launch) begin
                out_data_o   <= w_masked;
                out_nwords_o <= r_cnt;
                out_valid_o  <= 1'b1;
                // A word read at the launch edge starts the next packet.
                if (read_o) begin
                    r_acc <= c_PW'(fifo_data_i);
                    r_cnt <= c_CW'(1);
                end else begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            end else begin
                if (out_valid_o && out_ready_i) begin
                    out_valid_o <= 1'b0;
                end
                if (read_o) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_cnt == c_CW'(i)) begin
                            r_acc[i*DATA_LENGTH +: DATA_LENGTH] <= fifo_data_i;
                        end
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (read_o || (r_cnt == '0)) begin
                r_idle <= '0;
            end else if (r_idle != c_TMO) begin
                r_idle <= r_idle + 1'b1;
            end

            // A flush that cannot launch (output slot busy) is remembered.
            if (w_launch || (r_cnt == '0)) begin
                r_flush_pend <= 1'b0;
            end else if (flush_i) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tag_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_word_packer
// Description : Self-checking bench for tag_word_packer. A queue-based
//               packet model predicts read_o and the output register every
//               cycle; directed scenarios cover full packets, backpressure,
//               timeout, flush collision, idle flush and reset mid-packet,
//               followed by a randomized run with an end-to-end word order
//               check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_word_packer;

    localparam int DL = 32;
    localparam int W  = 4;
    localparam int T  = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [DL-1:0]   fifo_data_i;
    logic            empty_i;
    logic            read_o;
    logic            flush_i;
    logic [DL*W-1:0] out_data_o;
    logic [2:0]      out_nwords_o;
    logic            out_valid_o;
    logic            out_ready_i;

    tag_word_packer #(.DATA_LENGTH(DL), .WORDS(W), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_data_i  (fifo_data_i),
        .empty_i      (empty_i),
        .read_o       (read_o),
        .flush_i      (flush_i),
        .out_data_o   (out_data_o),
        .out_nwords_o (out_nwords_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Source and observation bookkeeping
    logic [DL-1:0]   src_q[$];
    logic [DL-1:0]   sent_q[$];
    logic [DL-1:0]   obs_words[$];
    logic [DL*W-1:0] obs_data[$];
    int              obs_n[$];

    // Reference model state: accumulator as a word queue plus output register
    logic [DL-1:0]   m_acc[$];
    int              m_idle;
    bit              m_fpend;
    bit              m_valid;
    logic [DL*W-1:0] m_data;
    int              m_n;

    bit chk_en = 1'b0;
    int cyc = 0;
    int read_cyc;
    int rise_cyc;
    int valid_hi;
    bit prev_v = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DL*W-1:0] pack_acc();
        logic [DL*W-1:0] r = '0;
        for (int i = 0; i < m_acc.size(); i++) r[i*DL +: DL] = m_acc[i];
        return r;
    endfunction

    task automatic drive_src();
        empty_i     = (src_q.size() == 0);
        fifo_data_i = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic push(input logic [DL-1:0] w);
        src_q.push_back(w);
        sent_q.push_back(w);
        drive_src();
    endtask

    task automatic clr();
        sent_q.delete();
        obs_words.delete();
        obs_data.delete();
        obs_n.delete();
        valid_hi = 0;
        read_cyc = -1;
        rise_cyc = -1;
    endtask

    task automatic cycle();
        bit m_read, slot, launch, dut_read;
        int sz;
        @(negedge clk);
        sz       = m_acc.size();
        m_read   = rstn && (src_q.size() > 0) && (sz < W);
        dut_read = read_o;
        if (chk_en) begin
            chk("read_o", read_o, m_read);
            chk("valid", out_valid_o, m_valid);
            chk("data", out_data_o, m_data);
            chk("nwords", out_nwords_o, m_n);
        end
        if (rstn && out_valid_o && out_ready_i) begin
            obs_data.push_back(out_data_o);
            obs_n.push_back(int'(out_nwords_o));
            for (int i = 0; i < int'(out_nwords_o) && i < W; i++)
                obs_words.push_back(out_data_o[i*DL +: DL]);
        end
        if (out_valid_o === 1'b1) valid_hi++;
        if (out_valid_o === 1'b1 && !prev_v) rise_cyc = cyc;
        prev_v = (out_valid_o === 1'b1);
        if (dut_read === 1'b1) read_cyc = cyc;

        if (!rstn) begin
            m_acc.delete();
            m_idle = 0; m_fpend = 0; m_valid = 0; m_data = '0; m_n = 0;
        end else begin
            slot   = !m_valid || out_ready_i;
            launch = slot && sz > 0 && (sz == W || flush_i || m_fpend || m_idle == T);
            if (launch) begin
                m_data = pack_acc(); m_n = sz; m_valid = 1; m_acc.delete();
            end else if (m_valid && out_ready_i) begin
                m_valid = 0;
            end
            if (m_read) m_acc.push_back(src_q[0]);
            m_idle  = (m_read || sz == 0) ? 0 : ((m_idle < T) ? m_idle + 1 : T);
            m_fpend = (launch || sz == 0) ? 1'b0 : (flush_i ? 1'b1 : m_fpend);
        end

        @(posedge clk);
        cyc++;
        #1;
        if (dut_read === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
        flush_i = 1'b0;
        drive_src();
    endtask

    task automatic stream_check(input string tag);
        chk({tag, "_len"}, obs_words.size(), sent_q.size());
        for (int i = 0; i < obs_words.size() && i < sent_q.size(); i++)
            chk({tag, "_word"}, obs_words[i], sent_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
        drive_src();
        clr();
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_nwords", out_nwords_o, 0);
        chk("rst_read", read_o, 0);
        rstn = 1'b1;

        // Full packet back-to-back
        clr();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        repeat (10) cycle();
        chk("full_pkts", obs_data.size(), 1);
        if (obs_data.size() > 0) begin
            chk("full_data", obs_data[0], 128'h000000A3_000000A2_000000A1_000000A0);
            chk("full_n", obs_n[0], 4);
        end
        chk("full_vcycles", valid_hi, 1);
        stream_check("full");

        // Backpressure with 12 words
        clr();
        out_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) push(32'hB0 + i);
        repeat (12) cycle();
        chk("bp_hold", out_data_o, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("bp_valid", out_valid_o, 1);
        chk("bp_read", read_o, 0);
        chk("bp_left", src_q.size(), 4);
        out_ready_i = 1'b1;
        repeat (30) cycle();
        chk("bp_pkts", obs_data.size(), 3);
        stream_check("bp");

        // Timeout on a single word
        clr();
        push(32'h55);
        repeat (20) cycle();
        chk("tmo_lat", rise_cyc - read_cyc, 10);
        chk("tmo_pkts", obs_data.size(), 1);
        if (obs_data.size() > 0) begin
            chk("tmo_data", obs_data[0], 128'h55);
            chk("tmo_n", obs_n[0], 1);
        end

        // Flush colliding with a read
        clr();
        push(32'h11); push(32'h22);
        cycle(); cycle();
        push(32'h77);
        flush_i = 1'b1;
        repeat (20) cycle();
        chk("fc_pkts", obs_data.size(), 2);
        if (obs_data.size() > 1) begin
            chk("fc_n0", obs_n[0], 2);
            chk("fc_d0", obs_data[0], 128'h00000022_00000011);
            chk("fc_n1", obs_n[1], 1);
            chk("fc_d1", obs_data[1], 128'h77);
        end
        stream_check("fc");

        // Flush while empty is ignored; next word waits the full timeout
        clr();
        flush_i = 1'b1;
        repeat (3) cycle();
        chk("fe_pkts", obs_data.size(), 0);
        push(32'h66);
        repeat (20) cycle();
        chk("fe_lat", rise_cyc - read_cyc, 10);
        chk("fe_pkts2", obs_data.size(), 1);

        // Reset with a held packet and a partial accumulator
        clr();
        out_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) push(32'hC0 + i);
        repeat (10) cycle();
        chk("mr_valid", out_valid_o, 1);
        rstn = 1'b0;
        cycle();
        chk("mr_valid0", out_valid_o, 0);
        chk("mr_data0", out_data_o, 0);
        chk("mr_n0", out_nwords_o, 0);
        chk("mr_read0", read_o, 0);
        rstn = 1'b1;
        clr();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hD0 + i);
        repeat (12) cycle();
        chk("mr_pkts", obs_data.size(), 1);
        if (obs_data.size() > 0) begin
            chk("mr_n", obs_n[0], 4);
            chk("mr_data", obs_data[0], 128'h000000D3_000000D2_000000D1_000000D0);
        end

        // Randomized traffic
        clr();
        repeat (3000) begin
            if ($urandom_range(0, 3) != 0 && src_q.size() < 2) push($urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        out_ready_i = 1'b1;
        repeat (40) cycle();
        stream_check("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
